// File: rtl/rr_dec_sel_gen_pkg.sv
// rr_dec_sel_gen_pkg: shared state encoding and requester count for the round-robin select generator
package rr_dec_sel_gen_pkg;
    localparam int N_REQ = 4;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_t;
endpackage

// File: rtl/rr_dec_sel_gen_if.sv
// rr_dec_sel_gen_if: request/hold inputs and decoder-drive outputs of the select generator
interface rr_dec_sel_gen_if #(parameter int HOLD_W = 4);
    import rr_dec_sel_gen_pkg::*;
    logic              en;
    logic [N_REQ-1:0]  req;
    logic [HOLD_W-1:0] hold;
    logic              dec_en;
    logic              sel1;
    logic              sel0;
    logic              busy;
    logic [1:0]        gnt_id;
    modport master(output en, req, hold, input dec_en, sel1, sel0, busy, gnt_id);
    modport slave(input en, req, hold, output dec_en, sel1, sel0, busy, gnt_id);
endinterface

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin pick, first set request at or after ptr (mod 4)
module rr_pick4
    import rr_dec_sel_gen_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [1:0]       i_ptr,
    input  logic             i_en,
    output logic             o_valid,
    output logic [1:0]       o_idx
);
    logic [N_REQ-1:0] w_rot;
    logic [1:0]       w_off;
    assign w_rot   = N_REQ'({i_req, i_req} >> i_ptr);
    assign w_off   = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : w_rot[3] ? 2'd3 : 2'd0;
    assign o_valid = i_en & |i_req;
    assign o_idx   = i_ptr + w_off;
endmodule

// File: rtl/rr_dec_sel_gen.sv
// rr_dec_sel_gen: round-robin enable/select driver for a 2-to-4 decoder with bounded grants and a dead cycle between grants
module rr_dec_sel_gen
    import rr_dec_sel_gen_pkg::*;
#(
    parameter int         HOLD_W  = 4,
    parameter logic [1:0] RST_PTR = 2'd0
)(
    input logic              clk,
    input logic              rst,
    rr_dec_sel_gen_if.slave  bus
);
    state_t            r_state, w_state_nxt;
    logic              r_dec_en, w_dec_en_nxt;
    logic              r_busy, w_busy_nxt;
    logic [1:0]        r_sel, w_sel_nxt;
    logic [1:0]        r_gnt_id, w_gnt_id_nxt;
    logic [1:0]        r_ptr, w_ptr_nxt;
    logic [HOLD_W-1:0] r_cnt, w_cnt_nxt;
    logic              w_valid;
    logic [1:0]        w_idx;
    logic [HOLD_W-1:0] w_hold_ld;
    logic              w_exit;

    rr_pick4 u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .i_en    (bus.en),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    assign w_hold_ld = (bus.hold == '0) ? HOLD_W'(1) : bus.hold;
    assign w_exit    = (r_cnt == HOLD_W'(1)) | ~bus.req[r_sel] | ~bus.en;

    // Next state: arbitrate from IDLE/GAP, end a grant on expiry, release or disable
    always_comb begin
        w_state_nxt  = r_state;
        w_dec_en_nxt = r_dec_en;
        w_busy_nxt   = r_busy;
        w_sel_nxt    = r_sel;
        w_gnt_id_nxt = r_gnt_id;
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;
        if (r_state == GRANT) begin
            w_cnt_nxt = r_cnt - HOLD_W'(1);
            if (w_exit) begin
                w_state_nxt  = GAP;
                w_dec_en_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
                w_ptr_nxt    = r_sel + 2'd1;
            end
        end else if (w_valid) begin
            w_state_nxt  = GRANT;
            w_dec_en_nxt = 1'b1;
            w_busy_nxt   = 1'b1;
            w_sel_nxt    = w_idx;
            w_gnt_id_nxt = w_idx;
            w_cnt_nxt    = w_hold_ld;
        end else begin
            w_state_nxt = IDLE;
        end
    end

    // State, counter, pointer and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_dec_en <= 1'b0;
            r_busy   <= 1'b0;
            r_sel    <= 2'd0;
            r_gnt_id <= 2'd0;
            r_ptr    <= RST_PTR;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_dec_en <= w_dec_en_nxt;
            r_busy   <= w_busy_nxt;
            r_sel    <= w_sel_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign bus.dec_en = r_dec_en;
    assign bus.sel1   = r_sel[1];
    assign bus.sel0   = r_sel[0];
    assign bus.busy   = r_busy;
    assign bus.gnt_id = r_gnt_id;
endmodule

// File: tb/tb_rr_dec_sel_gen.sv
// tb_rr_dec_sel_gen: directed vectors against a cycle model of the round-robin select generator
module tb_rr_dec_sel_gen;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   m_st, m_ptr, m_sel, m_gid, m_left, m_win;
    int   run_len;
    bit   run;
    logic [5:0] bp;

    rr_dec_sel_gen_if #(.HOLD_W(4)) bus ();
    rr_dec_sel_gen #(.HOLD_W(4), .RST_PTR(2'd0)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    // Free-running clock, rising edge active
    always #5 clk = ~clk;

    function automatic int pick(logic [3:0] r, int p, logic e);
        if (!e || r == 4'b0) return -1;
        for (int o = 0; o < 4; o++) if (r[(p + o) % 4]) return (p + o) % 4;
        return -1;
    endfunction

    // Winner the arbiter must choose from the current pointer
    always_comb m_win = pick(bus.req, m_ptr, bus.en);

    // Reference model: 0 idle, 1 granting with m_left cycles remaining, 2 dead cycle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st <= 0; m_ptr <= 0; m_sel <= 0; m_gid <= 0; m_left <= 0;
        end else if (m_st == 1) begin
            if (m_left == 1 || !bus.req[m_sel] || !bus.en) begin
                m_st  <= 2;
                m_ptr <= (m_sel + 1) % 4;
            end else m_left <= m_left - 1;
        end else if (m_win >= 0) begin
            m_st   <= 1;
            m_sel  <= m_win;
            m_gid  <= m_win;
            m_left <= (bus.hold == 4'd0) ? 1 : int'(bus.hold);
        end else m_st <= 0;
    end

    task automatic lit(string nm, logic [7:0] act, logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [5:0] act, exp;
        @(negedge clk);
        act = {bus.dec_en, bus.sel1, bus.sel0, bus.busy, bus.gnt_id};
        exp = {m_st == 1, 2'(m_sel), m_st == 1, 2'(m_gid)};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL model {dec_en,sel,busy,gnt_id}: got %b expected %b at %0t", act, exp, $time);
        end
    endtask

    task automatic pulse_rst();
        bus.req = 4'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.en = 1'b0; bus.req = 4'b0; bus.hold = 4'd0;
        rst = 1'b0;
        #1 rst = 1'b1;
        tick(); tick();
        lit("reset_outputs", {2'b0, bus.dec_en, bus.sel1, bus.sel0, bus.busy, bus.gnt_id}, 8'h00);
        // async reset mid-grant
        rst = 1'b0; bus.en = 1'b1; bus.req = 4'b0010; bus.hold = 4'd5;
        tick();
        lit("grant_before_rst", {bus.dec_en, bus.sel1, bus.sel0}, 8'h5);
        tick();
        #2 rst = 1'b1;
        #1 lit("async_rst", {bus.dec_en, bus.sel1, bus.sel0, bus.busy}, 8'h0);
        tick();
        rst = 1'b0; bus.req = 4'b0100; bus.hold = 4'd3;
        tick();
        lit("first_after_rst", {bus.dec_en, bus.sel1, bus.sel0, bus.gnt_id}, 8'h1A);
        bus.req = 4'b0;
        tick(); tick(); tick();
        // hold expiry, sole requester
        bus.req = 4'b0001; bus.hold = 4'd3;
        for (int i = 0; i < 6; i++) begin
            tick();
            bp[i] = bus.busy;
        end
        lit("hold_busy_pattern", {2'b0, bp}, 8'b00110111);
        lit("hold_sel", {bus.sel1, bus.sel0, bus.gnt_id}, 8'h0);
        // round robin, all requesting
        pulse_rst();
        bus.req = 4'b1111; bus.hold = 4'd2;
        for (int g = 0; g < 5; g++) begin
            tick();
            lit("rr_sel", {bus.dec_en, bus.sel1, bus.sel0, bus.gnt_id}, {5'b0, 1'b1, 2'(g)} << 2 | 8'(g % 4));
            tick(); tick();
            lit("rr_gap", {7'b0, bus.dec_en}, 8'h0);
        end
        // early release
        pulse_rst();
        bus.req = 4'b0010; bus.hold = 4'd10;
        tick(); tick();
        bus.req = 4'b0;
        tick();
        lit("release_gap", {7'b0, bus.dec_en}, 8'h0);
        tick();
        lit("release_idle", {7'b0, bus.dec_en}, 8'h0);
        bus.req = 4'b1111;
        tick();
        lit("ptr_after_release", {bus.dec_en, bus.sel1, bus.sel0}, 8'h6);
        // hold = 0 and en gating
        pulse_rst();
        bus.req = 4'b1000; bus.hold = 4'd0;
        repeat (5) tick();
        lit("hold0_grant", {bus.dec_en, bus.sel1, bus.sel0}, 8'h7);
        bus.en = 1'b0;
        repeat (4) begin
            tick();
            lit("en_low", {7'b0, bus.dec_en}, 8'h0);
        end
        bus.en = 1'b1;
        tick();
        lit("en_resume", {bus.dec_en, bus.sel1, bus.sel0}, 8'h7);
        // priority wrap after a grant to 3
        bus.req = 4'b1001; bus.hold = 4'd1;
        tick();
        lit("wrap_gap", {7'b0, bus.dec_en}, 8'h0);
        tick();
        lit("wrap_to_0", {bus.dec_en, bus.sel1, bus.sel0}, 8'h4);
        tick(); tick();
        lit("wrap_then_3", {bus.dec_en, bus.sel1, bus.sel0}, 8'h7);
        // en drop during a long grant
        pulse_rst();
        bus.req = 4'b0001; bus.hold = 4'd4;
        tick();
        bus.en = 1'b0;
        tick();
        lit("en_drop_grant", {7'b0, bus.dec_en}, 8'h0);
        bus.en = 1'b1;
        tick();
        // max hold, other channel toggling, hold changing mid-grant
        pulse_rst();
        bus.req = 4'b0100; bus.hold = 4'd15;
        tick();
        run_len = bus.busy ? 1 : 0;
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.req[0] = i[0];
            bus.hold = 4'(i);
            tick();
            if (run && bus.busy) run_len++;
            else run = 1'b0;
        end
        lit("max_hold_len", 8'(run_len), 8'd15);
        bus.req = 4'b0;
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rr_dec_sel_gen.md
Name: rr_dec_sel_gen

Overview:
- Round-robin select generator for 4 requesters; sits directly upstream of the team's 2-to-4 decoder.
- Drives the decoder's enable and 2-bit select so exactly one decoded line is active per grant.
- Inserts a dead cycle (enable low, decoder outputs high-Z) between consecutive grants.
- Grant length is bounded by a programmable hold count; a requester can release early.

Parameters:
- HOLD_W, 4, width of hold-count input and internal down-counter.
- RST_PTR, 0, requester index searched first after reset (0..3).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  block enable; low blocks new grants and ends any current grant.
- req  input  4  request lines; bit i = requester i.
- hold  input  HOLD_W  maximum grant length in cycles; 0 is treated as 1.
- dec_en  output  1  decoder enable (drives decoder en).
- sel1  output  1  select MSB (drives decoder in1).
- sel0  output  1  select LSB (drives decoder in0).
- busy  output  1  high while in GRANT.
- gnt_id  output  2  index of the most recently granted requester (sticky status).

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- All outputs are registered.
- Reset (asynchronous, effective immediately, including mid-grant):
  - state = IDLE; dec_en = 0; sel1 = 0; sel0 = 0; busy = 0.
  - gnt_id = 0; ptr = RST_PTR; counter = 0.
- States: IDLE, GRANT, GAP.
- Arbitration (combinational; evaluated in IDLE and GAP only):
  - Scan req starting at ptr, in order ptr, ptr+1, ... modulo 4.
  - The first set bit wins.
  - Valid only when en = 1 and req != 0.
- IDLE:
  - Arbitration valid at an edge -> next cycle GRANT, dec_en = 1, {sel1,sel0} = winner, gnt_id = winner.
  - Counter loads max(hold,1).
  - Otherwise stay in IDLE.
- GRANT:
  - dec_en = 1, busy = 1, {sel1,sel0} held constant.
  - Counter decrements each cycle.
  - Exit to GAP at the edge where any of these holds:
    - counter == 1 (hold expired), or
    - req[sel] == 0 (early release), or
    - en == 0.
  - On exit: ptr = (sel + 1) mod 4.
- GAP (exactly 1 cycle):
  - dec_en = 0, busy = 0, {sel1,sel0} keep the last value.
  - Arbitration valid -> GRANT next cycle (winner chosen with the updated ptr); else -> IDLE.
- Latency:
  - req sampled at edge k -> dec_en high from edge k (visible in cycle k+1).
  - Release sampled at edge k -> dec_en low in cycle k+1.
- Grant length: exactly max(hold,1) cycles when the request is held throughout.
  - hold is sampled only at grant start; changes during a grant are ignored.
- Fairness: a continuously requesting channel waits at most 3 grants plus 3 gap cycles.
- Boundary conditions:
  - hold = 0: 1-cycle grant.
  - hold = 2^HOLD_W-1: full count, no wrap; the counter never underflows (exit fires at 1).
  - ptr wrap: sel = 3 -> ptr = 0.
  - en low while in IDLE or GAP: no grant is issued; requests are ignored, not queued.
  - req for a non-granted channel toggling during GRANT: no effect.
  - Requester releases and re-requests in the same cycle: treated as held.
  - All 4 requesting continuously: grant order 0,1,2,3,0,... with 1 gap cycle between grants.
- dec_en and the select bits never change in the same cycle as a channel switch: the select changes only on the GAP->GRANT or IDLE->GRANT edge.

Decomposition:
- Shared include file (localparams):
  - state encoding: IDLE = 2'b00, GRANT = 2'b01, GAP = 2'b10.
  - N_REQ = 4.
- One sub-module, rr_pick4: purely combinational.
  - Inputs: req[3:0], ptr[1:0], en.
  - Outputs: valid, idx[1:0].
- The top level holds the FSM, counter, ptr and output registers.

Test Plan:
- Reset: assert rst mid-GRANT with dec_en = 1 -> dec_en, sel1, sel0, busy fall to 0 without waiting for a clock edge; after release, req = 4'b0100 with hold = 3 -> first grant is sel = 2.
- Hold expiry: req = 4'b0001 held, hold = 3 -> dec_en high exactly 3 cycles with sel = 00, then 1 GAP cycle, then re-grant of sel = 00 (sole requester), busy pattern 1,1,1,0,1...
- Round robin: req = 4'b1111, hold = 2 -> sel sequence 00,01,10,11,00 with each grant 2 cycles and 1 GAP cycle between; gnt_id tracks sel.
- Early release: req = 4'b0010, hold = 10; drop req[1] after 2 grant cycles -> dec_en low the next cycle, GAP then IDLE, ptr = 2.
- hold = 0 and en gating: hold = 0, req = 4'b1000 -> 1-cycle grants of sel = 11; deassert en mid-sequence -> grant ends next cycle, no further grants while en = 0, resume at en = 1.
- Priority wrap: after a grant to 3, req = 4'b1001 -> next grant is 0; then with req = 4'b1001 still held, the following grant is 3.
